// File: rtl/row_sync_arbiter.sv
// row_sync_arbiter
//   Shares one URAM row port among NUM_CORES cores. Within an epoch, each core
//   is granted at most once, in round-robin order. After every core has been
//   served, an external engine drains the URAM. A one-cycle broadcast pulse
//   then releases all cores into the next epoch.
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   i_core_req/locked       : per-core request / keep-grant flag
//   o_core_grant            : registered one-hot-or-zero grant
//   i_core_uram_*           : per-core URAM controls, packed core k at [k*W +: W]
//   o_URAM_*                : registered URAM port driven by the granted core
//   o_drain_req/i_drain_done: drain handshake with the external engine
//   o_uram_emptied          : one-cycle barrier-release pulse
module row_sync_arbiter #(
  parameter int unsigned NUM_CORES = 8,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          i_core_req,
  input  logic [NUM_CORES-1:0]          i_core_locked,
  output logic [NUM_CORES-1:0]          o_core_grant,
  output logic                          o_uram_emptied,
  input  logic [NUM_CORES-1:0]          i_core_uram_en,
  input  logic [NUM_CORES-1:0]          i_core_uram_wr_en,
  input  logic [NUM_CORES*ADDR_W-1:0]   i_core_uram_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   i_core_uram_wr_data,
  output logic                          o_URAM_en,
  output logic                          o_URAM_wr_en,
  output logic [ADDR_W-1:0]             o_URAM_addr,
  output logic [DATA_W-1:0]             o_URAM_wr_data,
  output logic                          o_drain_req,
  input  logic                          i_drain_done
);

  localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN, S_RELEASE} state_t;

  state_t                 r_state;
  logic [NUM_CORES-1:0]   r_served;
  logic [PTR_W-1:0]       r_rr_ptr;
  logic [PTR_W-1:0]       r_gnt_idx;
  logic [NUM_CORES-1:0]   r_grant;
  logic                   r_drain_req;
  logic                   r_emptied;
  logic                   r_uram_en;
  logic                   r_uram_wr_en;
  logic [ADDR_W-1:0]      r_uram_addr;
  logic [DATA_W-1:0]      r_uram_wr_data;

  state_t                 w_state_nxt;
  logic [NUM_CORES-1:0]   w_served_nxt;
  logic [PTR_W-1:0]       w_rr_nxt;
  logic [PTR_W-1:0]       w_gnt_idx_nxt;
  logic [NUM_CORES-1:0]   w_grant_nxt;
  logic                   w_drain_nxt;
  logic                   w_emptied_nxt;

  logic [NUM_CORES-1:0]   w_eligible;
  logic                   w_found;
  logic [PTR_W-1:0]       w_pick;
  logic [PTR_W:0]         w_cand;
  logic                   w_hold;

  logic                   w_uram_en;
  logic                   w_uram_wr_en;
  logic [ADDR_W-1:0]      w_uram_addr;
  logic [DATA_W-1:0]      w_uram_wr_data;

  assign w_eligible = i_core_req & ~r_served;
  assign w_hold     = i_core_req[r_gnt_idx] | i_core_locked[r_gnt_idx];

  // Round-robin search: first eligible core at rr_ptr, rr_ptr+1, ... (mod NUM_CORES)
  always_comb begin : rr_search
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_cand = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
      if (w_cand >= (PTR_W+1)'(NUM_CORES)) begin
        w_cand = w_cand - (PTR_W+1)'(NUM_CORES);
      end
      if (!w_found && w_eligible[w_cand[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[PTR_W-1:0];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin : fsm_next
    w_state_nxt   = r_state;
    w_served_nxt  = r_served;
    w_rr_nxt      = r_rr_ptr;
    w_gnt_idx_nxt = r_gnt_idx;
    w_grant_nxt   = r_grant;
    w_drain_nxt   = 1'b0;
    w_emptied_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Epoch-complete test takes priority over granting
        if (&r_served) begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = 1'b1;
        end else if (w_found) begin
          w_state_nxt   = S_GRANT;
          w_grant_nxt   = NUM_CORES'(1) << w_pick;
          w_gnt_idx_nxt = w_pick;
        end
      end
      S_GRANT: begin
        if (!w_hold) begin
          w_state_nxt             = S_IDLE;
          w_grant_nxt             = '0;
          w_served_nxt[r_gnt_idx] = 1'b1;
          w_rr_nxt = (r_gnt_idx == PTR_W'(NUM_CORES-1)) ? '0 : r_gnt_idx + PTR_W'(1);
        end
      end
      S_DRAIN: begin
        if (i_drain_done) begin
          w_state_nxt   = S_RELEASE;
          w_emptied_nxt = 1'b1;
        end else begin
          w_drain_nxt = 1'b1;
        end
      end
      S_RELEASE: begin
        w_state_nxt  = S_IDLE;
        w_served_nxt = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // AND-OR mux of the granted core's URAM controls; all zero with no grant
  always_comb begin : uram_mux
    w_uram_en      = 1'b0;
    w_uram_wr_en   = 1'b0;
    w_uram_addr    = '0;
    w_uram_wr_data = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_uram_en      = w_uram_en    | (r_grant[k] & i_core_uram_en[k]);
      w_uram_wr_en   = w_uram_wr_en | (r_grant[k] & i_core_uram_wr_en[k]);
      w_uram_addr    = w_uram_addr    | ({ADDR_W{r_grant[k]}} & i_core_uram_addr[k*ADDR_W +: ADDR_W]);
      w_uram_wr_data = w_uram_wr_data | ({DATA_W{r_grant[k]}} & i_core_uram_wr_data[k*DATA_W +: DATA_W]);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin : regs
    if (reset) begin
      r_state        <= S_IDLE;
      r_served       <= '0;
      r_rr_ptr       <= '0;
      r_gnt_idx      <= '0;
      r_grant        <= '0;
      r_drain_req    <= 1'b0;
      r_emptied      <= 1'b0;
      r_uram_en      <= 1'b0;
      r_uram_wr_en   <= 1'b0;
      r_uram_addr    <= '0;
      r_uram_wr_data <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_served       <= w_served_nxt;
      r_rr_ptr       <= w_rr_nxt;
      r_gnt_idx      <= w_gnt_idx_nxt;
      r_grant        <= w_grant_nxt;
      r_drain_req    <= w_drain_nxt;
      r_emptied      <= w_emptied_nxt;
      r_uram_en      <= w_uram_en;
      r_uram_wr_en   <= w_uram_wr_en;
      r_uram_addr    <= w_uram_addr;
      r_uram_wr_data <= w_uram_wr_data;
    end
  end

  assign o_core_grant   = r_grant;
  assign o_drain_req    = r_drain_req;
  assign o_uram_emptied = r_emptied;
  assign o_URAM_en      = r_uram_en;
  assign o_URAM_wr_en   = r_uram_wr_en;
  assign o_URAM_addr    = r_uram_addr;
  assign o_URAM_wr_data = r_uram_wr_data;

endmodule

// File: doc/row_sync_arbiter.md
ROW_SYNC_ARBITER -- requirements
Module: row_sync_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 8, number of cores sharing one URAM row port (2..16).
REQ-002 SHALL have parameter ADDR_W, default 12, URAM word-address width.
REQ-003 SHALL have parameter DATA_W, default 32, URAM write-data width.
REQ-004 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port i_core_req  in  NUM_CORES  per-core URAM access request.
REQ-007 SHALL have port i_core_locked  in  NUM_CORES  per-core "holding grant" flag.
REQ-008 SHALL have port o_core_grant  out  NUM_CORES  one-hot-or-zero grant, registered.
REQ-009 SHALL have port o_uram_emptied  out  1  broadcast barrier-release pulse to all cores.
REQ-010 SHALL have port i_core_uram_en / i_core_uram_wr_en  in  NUM_CORES each  per-core URAM enable / word write enable.
REQ-011 SHALL have port i_core_uram_addr  in  NUM_CORES*ADDR_W  packed per-core addresses, core k at [k*ADDR_W +: ADDR_W].
REQ-012 SHALL have port i_core_uram_wr_data  in  NUM_CORES*DATA_W  packed per-core write data, same packing.
REQ-013 SHALL have ports o_URAM_en (1), o_URAM_wr_en (1), o_URAM_addr (ADDR_W), o_URAM_wr_data (DATA_W)  out  registered URAM port.
REQ-014 SHALL have port o_drain_req  out  1  level request to external drain engine to empty the URAM.
REQ-015 SHALL have port i_drain_done  in  1  single-cycle pulse: drain complete.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT, DRAIN, RELEASE.
REQ-017 SHALL keep served mask (NUM_CORES bits) and round-robin pointer rr_ptr (clog2 NUM_CORES bits).
REQ-018 IDLE: eligible = i_core_req & ~served; if nonzero, SHALL pick first eligible index searching rr_ptr, rr_ptr+1, ... modulo NUM_CORES, set that grant bit, go GRANT.
REQ-019 IDLE: if served all ones, SHALL go DRAIN (checked before eligible search).
REQ-020 Grant latency: request sampled at edge t SHALL produce o_core_grant at edge t+1.
REQ-021 GRANT: while granted core has req or locked high, grant SHALL hold unchanged; other requests ignored.
REQ-022 GRANT: when granted core's req and locked both low, SHALL clear grant, set served bit, set rr_ptr = granted index + 1 (wrap to 0 past NUM_CORES-1), go IDLE; no grant in that IDLE cycle (minimum one-cycle gap between grants).
REQ-023 Requests from already-served cores SHALL be ignored until epoch ends.
REQ-024 DRAIN: o_drain_req=1; on i_drain_done=1 SHALL go RELEASE; i_drain_done outside DRAIN ignored.
REQ-025 RELEASE: o_uram_emptied=1 for exactly one cycle, served cleared, rr_ptr unchanged, next state IDLE.
REQ-026 URAM path: each cycle SHALL register granted core's en, wr_en, addr, wr_data onto o_URAM_*; with no grant all o_URAM_* SHALL register 0 (one-cycle latency).
REQ-027 o_core_grant SHALL never have more than one bit set.
REQ-028 o_drain_req and o_uram_emptied SHALL never be high together.

Reset
REQ-029 With reset high at an edge: state IDLE, served=0, rr_ptr=0, o_core_grant=0, o_URAM_*=0, o_drain_req=0, o_uram_emptied=0, next cycle.
REQ-030 Reset mid-GRANT or mid-DRAIN SHALL abort without completing the handoff; pending i_drain_done in the reset cycle dropped.

Verification
REQ-031 NUM_CORES=4, reset released, req=0b0110 same cycle -> grant 0b0010 one cycle later; core1 drops req/locked -> grant 0 next cycle, then 0b0100; rr_ptr=3 after core2 release.
REQ-032 Core0 granted, writes addr 0x0A5, data 0xDEADBEEF, wr_en=1 -> o_URAM_addr=0x0A5, o_URAM_wr_data=0xDEADBEEF, o_URAM_wr_en=1 exactly one cycle later; core3 simultaneously drives addr 0x123 -> not visible.
REQ-033 All 4 cores served in order 0,1,2,3 -> o_drain_req=1 next IDLE cycle; core0 re-requests -> no grant; i_drain_done pulse -> o_uram_emptied=1 one cycle, o_drain_req=0, then core0 granted.
REQ-034 Core2 granted with req low but locked high 10 cycles -> grant held all 10 cycles; locked drops -> grant released next edge.
REQ-035 Reset asserted while core1 granted and URAM write active -> next cycle grant=0, o_URAM_*=0, served=0; core1 re-requests -> granted again.
REQ-036 i_drain_done pulsed in IDLE with served=0 -> no o_uram_emptied, state unchanged.
